// File: rtl/axi_to_sram_like.sv
// AXI burst slave that issues one sram-like request per beat, one transaction at a time.
// Define AXI2SRAML_WR_PRIO_EN to give writes priority over reads when both arrive in IDLE.
module axi_to_sram_like (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] araddr,
    input  logic [3:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [3:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic        bvalid,
    input  logic        bready,
    output logic        sraml_req,
    output logic        sraml_wr,
    output logic [1:0]  sraml_size,
    output logic [31:0] sraml_addr,
    output logic [31:0] sraml_wdata,
    input  logic [31:0] sraml_rdata,
    input  logic        sraml_addr_ok,
    input  logic        sraml_data_ok
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] RD_RESP = 3'd3;
    localparam logic [2:0] WR_DATA = 3'd4;
    localparam logic [2:0] WR_REQ  = 3'd5;
    localparam logic [2:0] WR_WAIT = 3'd6;
    localparam logic [2:0] WR_RESP = 3'd7;

    logic [2:0]  state_r;
    logic [31:0] cur_addr_r;
    logic [1:0]  cur_size_r;
    logic [3:0]  len_r;
    logic [3:0]  cnt_r;
    logic [31:0] rdata_r;
    logic [31:0] wdata_r;
    logic [3:0]  wstrb_r;

    logic        ar_hs_s;
    logic        aw_hs_s;
    logic        last_beat_s;
    logic        wr_done_s;
    logic [31:0] next_addr_s;
    logic [3:0]  wr_fmt_s;
    logic        unused_s;

    // Byte-lane pattern to {size, address offset}; unusual patterns fall back to a full word.
    function automatic logic [3:0] wstrb_fmt(input logic [3:0] strb);
        case (strb)
            4'b0001: wstrb_fmt = {2'd0, 2'd0};
            4'b0010: wstrb_fmt = {2'd0, 2'd1};
            4'b0100: wstrb_fmt = {2'd0, 2'd2};
            4'b1000: wstrb_fmt = {2'd0, 2'd3};
            4'b0011: wstrb_fmt = {2'd1, 2'd0};
            4'b1100: wstrb_fmt = {2'd1, 2'd2};
            default: wstrb_fmt = {2'd2, 2'd0};
        endcase
    endfunction

    // Address-channel arbitration; ready is held low while in reset.
    always_comb begin
        arready = 1'b0;
        awready = 1'b0;
        if (rst_n && (state_r == IDLE)) begin
`ifdef AXI2SRAML_WR_PRIO_EN
            awready = 1'b1;
            arready = !awvalid;
`else
            arready = 1'b1;
            awready = !arvalid;
`endif
        end else begin
            arready = 1'b0;
            awready = 1'b0;
        end
    end

    // Write beat completion: skipped empty beat, or the sram-like access finished.
    always_comb begin
        wr_done_s = 1'b0;
        case (state_r)
            WR_DATA: wr_done_s = wvalid && (wstrb == 4'b0000);
            WR_REQ:  wr_done_s = sraml_addr_ok && sraml_data_ok;
            WR_WAIT: wr_done_s = sraml_data_ok;
            default: wr_done_s = 1'b0;
        endcase
    end

    assign ar_hs_s     = arvalid && arready;
    assign aw_hs_s     = awvalid && awready;
    assign last_beat_s = (cnt_r == len_r);
    assign next_addr_s = cur_addr_r + (32'd1 << cur_size_r);
    assign wr_fmt_s    = wstrb_fmt(wstrb_r);
    assign unused_s    = ^{wlast, arsize[2], awsize[2]};

    assign rvalid      = (state_r == RD_RESP);
    assign rdata       = rdata_r;
    assign rlast       = rvalid && last_beat_s;
    assign wready      = (state_r == WR_DATA);
    assign bvalid      = (state_r == WR_RESP);
    assign sraml_req   = (state_r == RD_REQ) || (state_r == WR_REQ);
    assign sraml_wr    = (state_r == WR_REQ);
    assign sraml_size  = (state_r == WR_REQ) ? wr_fmt_s[3:2] : cur_size_r;
    assign sraml_addr  = (state_r == WR_REQ) ? {cur_addr_r[31:2], wr_fmt_s[1:0]} : cur_addr_r;
    assign sraml_wdata = wdata_r;

    // Transaction sequencer and burst bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cur_addr_r <= 32'd0;
            cur_size_r <= 2'd0;
            len_r      <= 4'd0;
            cnt_r      <= 4'd0;
            rdata_r    <= 32'd0;
            wdata_r    <= 32'd0;
            wstrb_r    <= 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ar_hs_s) begin
                        cur_addr_r <= araddr;
                        cur_size_r <= arsize[1:0];
                        len_r      <= arlen;
                        cnt_r      <= 4'd0;
                        state_r    <= RD_REQ;
                    end else if (aw_hs_s) begin
                        cur_addr_r <= awaddr;
                        cur_size_r <= awsize[1:0];
                        len_r      <= awlen;
                        cnt_r      <= 4'd0;
                        state_r    <= WR_DATA;
                    end
                end
                RD_REQ: begin
                    if (sraml_addr_ok && sraml_data_ok) begin
                        rdata_r <= sraml_rdata;
                        state_r <= RD_RESP;
                    end else if (sraml_addr_ok) begin
                        state_r <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (sraml_data_ok) begin
                        rdata_r <= sraml_rdata;
                        state_r <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (rready && last_beat_s) begin
                        state_r <= IDLE;
                    end else if (rready) begin
                        cnt_r      <= cnt_r + 4'd1;
                        cur_addr_r <= next_addr_s;
                        state_r    <= RD_REQ;
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        wdata_r <= wdata;
                        wstrb_r <= wstrb;
                        if (wstrb != 4'b0000) begin
                            state_r <= WR_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (sraml_addr_ok && !sraml_data_ok) begin
                        state_r <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    state_r <= WR_WAIT;
                end
                WR_RESP: begin
                    if (bready) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
            // A finished write beat overrides the per-state transition above.
            if (wr_done_s) begin
                if (last_beat_s) begin
                    state_r <= WR_RESP;
                end else begin
                    cnt_r      <= cnt_r + 4'd1;
                    cur_addr_r <= next_addr_s;
                    state_r    <= WR_DATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_to_sram_like.sv
// Directed bench for axi_to_sram_like: table of single-beat writes plus hand-written burst,
// stall, arbitration and reset sequences against a simple one-cycle-latency sram-like slave.
module tb_axi_to_sram_like;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] araddr, awaddr, wdata, rdata, sraml_addr, sraml_wdata, sraml_rdata;
    logic [3:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;
    logic        sraml_req, sraml_wr, sraml_addr_ok, sraml_data_ok;
    logic [1:0]  sraml_size;

    always #5 clk = ~clk;

    axi_to_sram_like dut (
        .clk(clk), .rst_n(rst_n),
        .araddr(araddr), .arlen(arlen), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready),
        .sraml_req(sraml_req), .sraml_wr(sraml_wr), .sraml_size(sraml_size),
        .sraml_addr(sraml_addr), .sraml_wdata(sraml_wdata), .sraml_rdata(sraml_rdata),
        .sraml_addr_ok(sraml_addr_ok), .sraml_data_ok(sraml_data_ok)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr;
    } wvec_t;

    int          tests = 0;
    int          fails = 0;
    logic        pend = 1'b0;
    logic        slave_en = 1'b1;
    logic [31:0] rd_q = 32'd0;
    logic [31:0] rd_next = 32'd0;
    logic [31:0] log_addr [16];
    logic [1:0]  log_size [16];
    logic        log_wr [16];
    logic [31:0] log_wdata [16];
    int          log_n = 0;
    logic [31:0] beat_data [16];
    logic        beat_last [16];
    int          nbeats = 0;
    logic [31:0] wb_data [16];
    logic [3:0]  wb_strb [16];
    logic        bseen = 1'b0;
    wvec_t       wv [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // One clock: update slave inputs after the falling edge; caller may then drive/sample.
    task automatic step();
        @(negedge clk);
        sraml_data_ok = pend;
        sraml_rdata   = pend ? rd_q : 32'd0;
        pend          = 1'b0;
        #1;
        sraml_addr_ok = slave_en && sraml_req;
        if (sraml_addr_ok) begin
            if (log_n < 16) begin
                log_addr[log_n]  = sraml_addr;
                log_size[log_n]  = sraml_size;
                log_wr[log_n]    = sraml_wr;
                log_wdata[log_n] = sraml_wdata;
            end
            log_n++;
            pend    = 1'b1;
            rd_q    = rd_next;
            rd_next = rd_next + 32'd1;
        end
        #1;
    endtask

    task automatic axi_read(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size);
        int guard;
        log_n  = 0;
        nbeats = 0;
        step();
        araddr = addr; arlen = len; arsize = size; arvalid = 1'b1; rready = 1'b1;
        #1;
        guard = 0;
        while (!arready && guard < 20) begin step(); #1; guard++; end
        chk("ar_accept", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        #1;
        guard = 0;
        while (nbeats <= int'(len) && guard < 100) begin
            if (rvalid) begin
                if (nbeats < 16) begin
                    beat_data[nbeats] = rdata;
                    beat_last[nbeats] = rlast;
                end
                nbeats++;
            end
            step();
            #1;
            guard++;
        end
        chk("read_beat_count", 32'(nbeats), 32'(len) + 32'd1);
        rready = 1'b0;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [3:0] len, input logic [2:0] size);
        int guard;
        log_n = 0;
        bseen = 1'b0;
        step();
        awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
        #1;
        guard = 0;
        while (!awready && guard < 20) begin step(); #1; guard++; end
        chk("aw_accept", 32'(awready), 32'd1);
        for (int b = 0; b <= int'(len); b++) begin
            step();
            awvalid = 1'b0; wvalid = 1'b1; wdata = wb_data[b]; wstrb = wb_strb[b];
            wlast = (b == int'(len));
            #1;
            guard = 0;
            while (!wready && guard < 20) begin step(); #1; guard++; end
            chk("w_accept", 32'(wready), 32'd1);
        end
        step();
        wvalid = 1'b0; bready = 1'b1;
        #1;
        guard = 0;
        while (!bvalid && guard < 40) begin step(); #1; guard++; end
        bseen = bvalid;
        step();
        bready = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        wv[0] = '{32'h0000_2002, 4'b1100, 32'h5566_0000, 2'd1, 32'h0000_2002};
        wv[1] = '{32'h0000_2100, 4'b0001, 32'h0000_00AA, 2'd0, 32'h0000_2100};
        wv[2] = '{32'h0000_2100, 4'b0010, 32'h0000_BB00, 2'd0, 32'h0000_2101};
        wv[3] = '{32'h0000_2100, 4'b0100, 32'h00CC_0000, 2'd0, 32'h0000_2102};
        wv[4] = '{32'h0000_2103, 4'b1000, 32'hDD00_0000, 2'd0, 32'h0000_2103};
        wv[5] = '{32'h0000_2106, 4'b0011, 32'h0000_1234, 2'd1, 32'h0000_2104};
        wv[6] = '{32'h0000_2200, 4'b1111, 32'hCAFE_F00D, 2'd2, 32'h0000_2200};
        wv[7] = '{32'h0000_2201, 4'b0110, 32'h0012_3400, 2'd2, 32'h0000_2200};

        rst_n = 1'b0;
        araddr = 32'd0; arlen = 4'd0; arsize = 3'd0; arvalid = 1'b0; rready = 1'b0;
        awaddr = 32'd0; awlen = 4'd0; awsize = 3'd0; awvalid = 1'b0;
        wdata = 32'd0; wstrb = 4'd0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        sraml_rdata = 32'd0; sraml_addr_ok = 1'b0; sraml_data_ok = 1'b0;

        // Reset: everything low even with valids pending.
        #2;
        arvalid = 1'b1; awvalid = 1'b1;
        #1;
        chk("rst_arready", 32'(arready), 32'd0);
        chk("rst_awready", 32'(awready), 32'd0);
        chk("rst_ctrl", 32'({rvalid, rlast, wready, bvalid, sraml_req, sraml_wr, sraml_size}), 32'd0);
        chk("rst_sraml_addr", sraml_addr, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_sraml_wdata", sraml_wdata, 32'd0);
        arvalid = 1'b0; awvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Table of single-beat writes covering every strobe decode.
        for (int i = 0; i < 8; i++) begin
            wb_data[0] = wv[i].data;
            wb_strb[0] = wv[i].strb;
            axi_write(wv[i].addr, 4'd0, 3'd2);
            chk($sformatf("wv%0d_nreq", i), 32'(log_n), 32'd1);
            chk($sformatf("wv%0d_wr", i), 32'(log_wr[0]), 32'd1);
            chk($sformatf("wv%0d_size", i), 32'(log_size[0]), 32'(wv[i].exp_size));
            chk($sformatf("wv%0d_addr", i), log_addr[0], wv[i].exp_addr);
            chk($sformatf("wv%0d_wdata", i), log_wdata[0], wv[i].data);
            chk($sformatf("wv%0d_bvalid", i), 32'(bseen), 32'd1);
        end

        // Four-beat word read burst.
        rd_next = 32'hA0;
        axi_read(32'h0000_1000, 4'd3, 3'd2);
        chk("rd4_nreq", 32'(log_n), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rd4_addr%0d", i), log_addr[i], 32'h0000_1000 + 32'(4 * i));
            chk($sformatf("rd4_size%0d", i), 32'({log_wr[i], log_size[i]}), 32'd2);
            chk($sformatf("rd4_data%0d", i), beat_data[i], 32'hA0 + 32'(i));
            chk($sformatf("rd4_last%0d", i), 32'(beat_last[i]), (i == 3) ? 32'd1 : 32'd0);
        end

        // Address wraps past the top of the map; byte bursts step by one.
        rd_next = 32'h10;
        axi_read(32'hFFFF_FFFC, 4'd1, 3'd2);
        chk("wrap_addr1", log_addr[1], 32'h0000_0000);
        chk("wrap_data1", beat_data[1], 32'h11);
        rd_next = 32'h20;
        axi_read(32'h0000_5001, 4'd1, 3'd0);
        chk("byte_addr0", log_addr[0], 32'h0000_5001);
        chk("byte_addr1", log_addr[1], 32'h0000_5002);
        chk("byte_size1", 32'(log_size[1]), 32'd0);

        // Empty-strobe beats consume a beat without an access.
        wb_data[0] = 32'h1111_1111; wb_strb[0] = 4'hF;
        wb_data[1] = 32'h9999_9999; wb_strb[1] = 4'h0;
        axi_write(32'h0000_4000, 4'd1, 3'd2);
        chk("zs_tail_nreq", 32'(log_n), 32'd1);
        chk("zs_tail_addr", log_addr[0], 32'h0000_4000);
        chk("zs_tail_bvalid", 32'(bseen), 32'd1);
        wb_data[0] = 32'h9999_9999; wb_strb[0] = 4'h0;
        wb_data[1] = 32'h2222_2222; wb_strb[1] = 4'hF;
        axi_write(32'h0000_4000, 4'd1, 3'd2);
        chk("zs_head_nreq", 32'(log_n), 32'd1);
        chk("zs_head_addr", log_addr[0], 32'h0000_4004);
        chk("zs_head_wdata", log_wdata[0], 32'h2222_2222);

        // Simultaneous AR/AW in IDLE; valids withdrawn before the edge.
        step();
        arvalid = 1'b1; awvalid = 1'b1;
        #1;
`ifdef AXI2SRAML_WR_PRIO_EN
        chk("arb_arready", 32'(arready), 32'd0);
        chk("arb_awready", 32'(awready), 32'd1);
`else
        chk("arb_arready", 32'(arready), 32'd1);
        chk("arb_awready", 32'(awready), 32'd0);
`endif
        arvalid = 1'b0; awvalid = 1'b0;

        // Single-beat read timing, then rready held low for five cycles.
        rd_next = 32'hC3;
        log_n = 0;
        step();
        araddr = 32'h0000_3000; arlen = 4'd0; arsize = 3'd2; arvalid = 1'b1; rready = 1'b0;
        #1;
        chk("t0_arready", 32'(arready), 32'd1);
        step();
        arvalid = 1'b0;
        #1;
        chk("t1_req", 32'(sraml_req), 32'd1);
        chk("t1_addr", sraml_addr, 32'h0000_3000);
        step();
        #1;
        chk("t2_req_dropped", 32'(sraml_req), 32'd0);
        chk("t2_rvalid", 32'(rvalid), 32'd0);
        step();
        #1;
        chk("t3_rvalid", 32'(rvalid), 32'd1);
        chk("t3_rdata", rdata, 32'hC3);
        chk("t3_rlast", 32'(rlast), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            #1;
            chk($sformatf("stall%0d_rvalid", i), 32'(rvalid), 32'd1);
            chk($sformatf("stall%0d_rdata", i), rdata, 32'hC3);
            chk($sformatf("stall%0d_req", i), 32'(sraml_req), 32'd0);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        #1;
        chk("stall_done_rvalid", 32'(rvalid), 32'd0);
        chk("stall_nreq", 32'(log_n), 32'd1);

        // Single-beat write timing.
        step();
        awaddr = 32'h0000_7000; awlen = 4'd0; awsize = 3'd2; awvalid = 1'b1;
        #1;
        chk("wt0_awready", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h7777_0001; wstrb = 4'hF; wlast = 1'b1;
        #1;
        chk("wt1_wready", 32'(wready), 32'd1);
        step();
        wvalid = 1'b0;
        #1;
        chk("wt2_req", 32'({sraml_req, sraml_wr}), 32'd3);
        chk("wt2_wdata", sraml_wdata, 32'h7777_0001);
        step();
        #1;
        chk("wt3_bvalid", 32'(bvalid), 32'd0);
        step();
        #1;
        chk("wt4_bvalid", 32'(bvalid), 32'd1);
        bready = 1'b1;
        step();
        bready = 1'b0;
        #1;
        chk("wt5_bvalid", 32'(bvalid), 32'd0);

        // Reset while waiting for read data, then a clean read afterwards.
        rd_next = 32'h55;
        step();
        araddr = 32'h0000_6000; arlen = 4'd0; arsize = 3'd2; arvalid = 1'b1; rready = 1'b1;
        #1;
        step();
        arvalid = 1'b0;
        #1;
        pend = 1'b0;
        step();
        #1;
        chk("prerst_addr", sraml_addr, 32'h0000_6000);
        arvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_arready", 32'(arready), 32'd0);
        chk("midrst_ctrl", 32'({rvalid, rlast, wready, bvalid, sraml_req, sraml_wr, sraml_size}), 32'd0);
        chk("midrst_addr", sraml_addr, 32'd0);
        arvalid = 1'b0; rready = 1'b0;
        step();
        rst_n = 1'b1;
        rd_next = 32'h77;
        axi_read(32'h0000_6100, 4'd0, 3'd2);
        chk("postrst_addr", log_addr[0], 32'h0000_6100);
        chk("postrst_data", beat_data[0], 32'h77);
        chk("postrst_last", 32'(beat_last[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
